// File: rtl/fifo_read_streamer.sv
`timescale 1ns/1ps
// fifo_read_streamer
//   Read-side consumer for the async FIFO. Pops words from the fall-through
//   read port whenever they exist and the downstream can absorb them, and
//   re-presents them as a valid/ready stream through a 2-entry skid buffer.
//   This sustains 1 word/cycle under backpressure. A wrapping pop counter
//   allows a scoreboard cross-check against the write side.
//
// Ports
//   rclk       read-domain clock, all state on posedge
//   rrst       asynchronous, active-high reset
//   enable     1 = pops allowed, 0 = no new rinc
//   rempty     FIFO empty flag
//   rdata      FIFO head word, valid while rempty==0
//   rinc       pop strobe to the FIFO, one word per edge with rinc=1
//   m_valid    output stream word valid
//   m_data     output stream word, always driven from a register
//   m_ready    downstream accepts when m_valid & m_ready
//   pop_count  words popped since reset, wraps mod 2^CNT_W
module fifo_read_streamer #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             rclk,
   input  logic             rrst,
   input  logic             enable,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic             m_valid,
   output logic [DSIZE-1:0] m_data,
   input  logic             m_ready,
   output logic [CNT_W-1:0] pop_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   occ_e             cnt_q, cnt_d;
   logic [DSIZE-1:0] slot0_q, slot0_d;
   logic [DSIZE-1:0] slot1_q, slot1_d;
   logic [CNT_W-1:0] pop_count_q, pop_count_d;
   logic             fire;
   logic             pop;

   always_comb begin
      // With both slots full a pop is only safe when the head leaves this
      // same edge, which makes rinc combinational from m_ready.
      rinc        = !rrst && enable && !rempty && ((cnt_q != TWO) || m_ready);
      fire        = (cnt_q != EMPTY) && m_ready;
      pop         = rinc;
      cnt_d       = cnt_q;
      slot0_d     = slot0_q;
      slot1_d     = slot1_q;
      pop_count_d = pop ? pop_count_q + CNT_W'(1) : pop_count_q;

      case ({pop, fire})
         2'b10: begin
            // pop only: new word lands in the first free slot
            case (cnt_q)
               EMPTY: begin
                  slot0_d = rdata;
                  cnt_d   = ONE;
               end
               ONE: begin
                  slot1_d = rdata;
                  cnt_d   = TWO;
               end
               default: ;
            endcase
         end
         2'b01: begin
            // fire only: shift the tail up to the head
            case (cnt_q)
               ONE: cnt_d = EMPTY;
               TWO: begin
                  slot0_d = slot1_q;
                  cnt_d   = ONE;
               end
               default: ;
            endcase
         end
         2'b11: begin
            // pop and fire: occupancy unchanged, queue advances by one
            case (cnt_q)
               ONE: slot0_d = rdata;
               TWO: begin
                  slot0_d = slot1_q;
                  slot1_d = rdata;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         cnt_q       <= EMPTY;
         slot0_q     <= '0;
         slot1_q     <= '0;
         pop_count_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         slot0_q     <= slot0_d;
         slot1_q     <= slot1_d;
         pop_count_q <= pop_count_d;
      end
   end

   assign m_valid   = (cnt_q != EMPTY);
   assign m_data    = slot0_q;
   assign pop_count = pop_count_q;

endmodule

// File: tb/tb_fifo_read_streamer.sv
`timescale 1ns/1ps
module tb_fifo_read_streamer;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned CNT_W = 4;

   logic             rclk = 1'b0;
   logic             rrst;
   logic             enable;
   logic             rempty;
   logic [DSIZE-1:0] rdata;
   logic             rinc;
   logic             m_valid;
   logic [DSIZE-1:0] m_data;
   logic             m_ready;
   logic [CNT_W-1:0] pop_count;

   int checks   = 0;
   int failures = 0;

   logic [DSIZE-1:0] fifo_q[$];
   logic [DSIZE-1:0] sb_q[$];
   logic             pop_pending = 1'b0;
   logic             stall_prev  = 1'b0;
   logic [DSIZE-1:0] stall_data  = '0;

   always #5 rclk = ~rclk;

   fifo_read_streamer #(
      .DSIZE(DSIZE),
      .CNT_W(CNT_W)
   ) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .enable    (enable),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .pop_count (pop_count)
   );

   function automatic void refresh();
      rempty = (fifo_q.size() == 0);
      rdata  = rempty ? 'x : fifo_q[0];
   endfunction

   task automatic push_word(input logic [DSIZE-1:0] w);
      fifo_q.push_back(w);
      sb_q.push_back(w);
      refresh();
   endtask

   // Fall-through FIFO model: rinc seen mid-cycle pops the head after the edge.
   always @(negedge rclk) pop_pending = rinc;
   always @(posedge rrst) pop_pending = 1'b0;
   always @(posedge rclk) begin
      #1;
      if (pop_pending) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         pop_pending = 1'b0;
         refresh();
      end
   end

   // Stream monitor: order against scoreboard, no pop while empty, stall hold.
   always @(negedge rclk) begin
      if (!rrst) begin
         if (rempty) begin
            checks++;
            if (rinc !== 1'b0) begin
               failures++;
               $display("FAIL rinc_while_empty: rinc=%b required 0", rinc);
            end
         end
         if (stall_prev) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== stall_data) begin
               failures++;
               $display("FAIL stall_hold: m_valid=%b m_data=%h required 1/%h",
                        m_valid, m_data, stall_data);
            end
         end
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word: m_data=%h with empty scoreboard", m_data);
            end else begin
               logic [DSIZE-1:0] exp;
               exp = sb_q.pop_front();
               if (m_data !== exp) begin
                  failures++;
                  $display("FAIL order: m_data=%h required %h", m_data, exp);
               end
            end
         end
         stall_prev = (m_valid === 1'b1) && (m_ready === 1'b0);
         stall_data = m_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic test_reset();
      rrst    = 1'b1;
      enable  = 1'b1;
      m_ready = 1'b1;
      fifo_q.push_back(8'hA5);
      refresh();
      repeat (2) @(negedge rclk);
      checks++;
      if (rinc !== 1'b0) begin
         failures++; $display("FAIL reset_rinc: rinc=%b required 0", rinc);
      end
      checks++;
      if (m_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: m_valid=%b required 0", m_valid);
      end
      checks++;
      if (m_data !== 8'h00) begin
         failures++; $display("FAIL reset_data: m_data=%h required 00", m_data);
      end
      checks++;
      if (pop_count !== 4'd0) begin
         failures++; $display("FAIL reset_count: pop_count=%0d required 0", pop_count);
      end
      enable = 1'b0;
      fifo_q.delete();
      refresh();
      @(posedge rclk); #1;
      rrst = 1'b0;
      @(negedge rclk);
      checks++;
      if (m_valid !== 1'b0) begin
         failures++; $display("FAIL reset_release_valid: m_valid=%b required 0", m_valid);
      end
   endtask

   task automatic test_stream();
      logic [DSIZE-1:0] w[3];
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
      @(posedge rclk); #1;
      m_ready = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 3; i++) push_word(w[i]);
      for (int i = 0; i < 3; i++) begin
         @(negedge rclk);
         checks++;
         if (rinc !== 1'b1) begin
            failures++; $display("FAIL stream_rinc: cycle %0d rinc=%b required 1", i, rinc);
         end
         if (i > 0) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== w[i-1]) begin
               failures++;
               $display("FAIL stream_data: cycle %0d m_valid=%b m_data=%h required 1/%h",
                        i, m_valid, m_data, w[i-1]);
            end
         end
      end
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h33) begin
         failures++;
         $display("FAIL stream_last: rinc=%b m_valid=%b m_data=%h required 0/1/33",
                  rinc, m_valid, m_data);
      end
      @(negedge rclk);
      checks++;
      if (m_valid !== 1'b0 || pop_count !== 4'd3 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL stream_end: m_valid=%b pop_count=%0d sb=%0d required 0/3/0",
                  m_valid, pop_count, sb_q.size());
      end
   endtask

   task automatic test_backpressure();
      logic [DSIZE-1:0] w[5];
      for (int i = 0; i < 5; i++) w[i] = 8'h40 + DSIZE'(i);
      @(posedge rclk); #1;
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_word(w[i]);
      repeat (6) @(negedge rclk);
      checks++;
      if (fifo_q.size() != 3 || pop_count !== 4'd5 || rinc !== 1'b0) begin
         failures++;
         $display("FAIL bp_pops: fifo_left=%0d pop_count=%0d rinc=%b required 3/5/0",
                  fifo_q.size(), pop_count, rinc);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== w[0]) begin
         failures++;
         $display("FAIL bp_head: m_valid=%b m_data=%h required 1/%h", m_valid, m_data, w[0]);
      end
      @(posedge rclk); #1;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge rclk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== w[i]) begin
            failures++;
            $display("FAIL bp_drain: word %0d m_valid=%b m_data=%h required 1/%h",
                     i, m_valid, m_data, w[i]);
         end
      end
      @(negedge rclk);
      checks++;
      if (m_valid !== 1'b0 || pop_count !== 4'd8 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL bp_end: m_valid=%b pop_count=%0d sb=%0d required 0/8/0",
                  m_valid, pop_count, sb_q.size());
      end
   endtask

   task automatic test_gate();
      logic [DSIZE-1:0] w[4];
      for (int i = 0; i < 4; i++) w[i] = 8'h60 + DSIZE'(i);
      @(posedge rclk); #1;
      m_ready = 1'b1;
      enable  = 1'b1;
      for (int i = 0; i < 4; i++) push_word(w[i]);
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b1) begin
         failures++; $display("FAIL gate_first: rinc=%b required 1", rinc);
      end
      @(posedge rclk); #1;
      enable = 1'b0;
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b0 || m_valid !== 1'b1 || m_data !== w[0]) begin
         failures++;
         $display("FAIL gate_off: rinc=%b m_valid=%b m_data=%h required 0/1/%h",
                  rinc, m_valid, m_data, w[0]);
      end
      repeat (3) @(negedge rclk);
      checks++;
      if (fifo_q.size() != 3 || m_valid !== 1'b0 || pop_count !== 4'd9 || rinc !== 1'b0) begin
         failures++;
         $display("FAIL gate_hold: fifo_left=%0d m_valid=%b pop_count=%0d rinc=%b required 3/0/9/0",
                  fifo_q.size(), m_valid, pop_count, rinc);
      end
      @(posedge rclk); #1;
      enable = 1'b1;
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b1) begin
         failures++; $display("FAIL gate_resume: rinc=%b required 1", rinc);
      end
      for (int i = 1; i < 4; i++) begin
         @(negedge rclk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== w[i]) begin
            failures++;
            $display("FAIL gate_data: word %0d m_valid=%b m_data=%h required 1/%h",
                     i, m_valid, m_data, w[i]);
         end
      end
      @(negedge rclk);
      checks++;
      if (m_valid !== 1'b0 || pop_count !== 4'd12 || sb_q.size() != 0 || fifo_q.size() != 0) begin
         failures++;
         $display("FAIL gate_end: m_valid=%b pop_count=%0d sb=%0d fifo=%0d required 0/12/0/0",
                  m_valid, pop_count, sb_q.size(), fifo_q.size());
      end
   endtask

   task automatic test_reset_midop();
      logic [DSIZE-1:0] w[4];
      for (int i = 0; i < 4; i++) w[i] = 8'h80 + DSIZE'(i);
      @(posedge rclk); #1;
      m_ready = 1'b0;
      enable  = 1'b1;
      for (int i = 0; i < 4; i++) push_word(w[i]);
      repeat (4) @(negedge rclk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== w[0] || fifo_q.size() != 2) begin
         failures++;
         $display("FAIL midrst_full: m_valid=%b m_data=%h fifo_left=%0d required 1/%h/2",
                  m_valid, m_data, fifo_q.size(), w[0]);
      end
      #2;
      rrst = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || pop_count !== 4'd0 || rinc !== 1'b0 || m_data !== 8'h00) begin
         failures++;
         $display("FAIL midrst_async: m_valid=%b pop_count=%0d rinc=%b m_data=%h required 0/0/0/00",
                  m_valid, pop_count, rinc, m_data);
      end
      // the two buffered words are discarded by reset
      void'(sb_q.pop_front());
      void'(sb_q.pop_front());
      @(posedge rclk); #1;
      @(posedge rclk); #1;
      rrst    = 1'b0;
      m_ready = 1'b1;
      @(negedge rclk);
      checks++;
      if (rinc !== 1'b1) begin
         failures++; $display("FAIL midrst_resume: rinc=%b required 1", rinc);
      end
      for (int i = 2; i < 4; i++) begin
         @(negedge rclk);
         checks++;
         if (m_valid !== 1'b1 || m_data !== w[i]) begin
            failures++;
            $display("FAIL midrst_data: word %0d m_valid=%b m_data=%h required 1/%h",
                     i, m_valid, m_data, w[i]);
         end
      end
      @(negedge rclk);
      checks++;
      if (m_valid !== 1'b0 || pop_count !== 4'd2 || sb_q.size() != 0) begin
         failures++;
         $display("FAIL midrst_end: m_valid=%b pop_count=%0d sb=%0d required 0/2/0",
                  m_valid, pop_count, sb_q.size());
      end
   endtask

   task automatic test_wrap();
      @(posedge rclk); #1;
      rrst = 1'b1;
      @(posedge rclk); #1;
      rrst    = 1'b0;
      m_ready = 1'b1;
      enable  = 1'b1;
      @(negedge rclk);
      checks++;
      if (pop_count !== 4'd0) begin
         failures++; $display("FAIL wrap_start: pop_count=%0d required 0", pop_count);
      end
      @(posedge rclk); #1;
      for (int i = 0; i < 17; i++) push_word(8'hC0 + DSIZE'(i));
      repeat (22) @(negedge rclk);
      checks++;
      if (pop_count !== 4'd1) begin
         failures++; $display("FAIL wrap_count: pop_count=%0d required 1", pop_count);
      end
      checks++;
      if (m_valid !== 1'b0 || sb_q.size() != 0 || fifo_q.size() != 0) begin
         failures++;
         $display("FAIL wrap_drain: m_valid=%b sb=%0d fifo=%0d required 0/0/0",
                  m_valid, sb_q.size(), fifo_q.size());
      end
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL timeout: simulation did not finish within time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      rrst    = 1'b1;
      enable  = 1'b0;
      m_ready = 1'b0;
      refresh();
      test_reset();
      test_stream();
      test_backpressure();
      test_gate();
      test_reset_midop();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
